// File: rtl/cva5_types.sv
// Shared rename/issue types: physical register addressing and ready-table update records.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cva5_types;

   // Physical registers per register file (GP and FP files are the same size)
   localparam int unsigned PHYS_REG_COUNT = 64;
   localparam int unsigned PHYS_ADDR_W    = $clog2(PHYS_REG_COUNT);

   typedef logic [PHYS_ADDR_W-1:0] phys_addr_t;

   // One request to change a ready bit; set=1 marks ready, set=0 marks not ready
   typedef struct packed {
      logic       valid;
      phys_addr_t addr;
      logic       set;
   } ready_table_update_t;

endpackage

// File: rtl/phys_reg_set_decoder.sv
// Folds a list of address/valid update records into a one-hot-per-address set mask.
// Latency: purely combinational.
// Backpressure: none; every valid record is always accepted.
module phys_reg_set_decoder
   import cva5_types::*;
#(
   parameter int unsigned NUM_PHYS = PHYS_REG_COUNT,
   parameter int unsigned NUM_UPD  = 4
) (
   input  ready_table_update_t upd [NUM_UPD],
   output logic [NUM_PHYS-1:0] set_mask
);

   // OR every valid set request into its address bit; duplicates collapse to one bit
   always_comb begin
      set_mask = '0;
      for (int k = 0; k < NUM_UPD; k++) begin
         if (upd[k].valid && upd[k].set) begin
            set_mask[upd[k].addr] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/phys_reg_ready_table.sv
// Per-physical-register ready bits: alloc clears, writeback/rollback sets, issue reads with wb bypass.
// Latency: table and count update next cycle; rs_ready is combinational (zero-cycle wb bypass).
// Backpressure: none; all requests are accepted every cycle once init_done is high.
module phys_reg_ready_table
   import cva5_types::*;
#(
   parameter  int unsigned NUM_PHYS       = PHYS_REG_COUNT,
   parameter  int unsigned NUM_READ_PORTS = 2,
   parameter  int unsigned NUM_WB_PORTS   = 3,
   localparam int unsigned PHYS_W         = $clog2(NUM_PHYS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             alloc_valid,
   input  logic [PHYS_W-1:0]                alloc_phys,
   input  logic                             rollback_valid,
   input  logic [PHYS_W-1:0]                rollback_phys,
   input  logic [NUM_WB_PORTS-1:0]          wb_valid,
   input  logic [NUM_WB_PORTS*PHYS_W-1:0]   wb_phys,
   input  logic [NUM_READ_PORTS*PHYS_W-1:0] rs_phys,
   output logic [NUM_READ_PORTS-1:0]        rs_ready,
   output logic [PHYS_W:0]                  not_ready_count,
   output logic                             init_done
);

   localparam int unsigned NUM_UPD = NUM_WB_PORTS + 1;

   logic [NUM_PHYS-1:0] ready_q, ready_d;
   logic [PHYS_W:0]     count_q, count_d;
   logic                init_done_q, init_done_d;

   ready_table_update_t upd [NUM_UPD];
   logic [NUM_PHYS-1:0] set_mask;
   logic [NUM_PHYS-1:0] clr_mask;
   logic [NUM_PHYS-1:0] eff_set;
   logic [NUM_PHYS-1:0] eff_clr;
   logic [PHYS_W:0]     dec_cnt;
   logic [PHYS_W:0]     not_ready_pop;

   // Writeback ports and rollback all become "set" records; nothing is applied before init_done
   always_comb begin
      for (int j = 0; j < NUM_WB_PORTS; j++) begin
         upd[j].valid = init_done_q & wb_valid[j];
         upd[j].addr  = phys_addr_t'(wb_phys[j*PHYS_W +: PHYS_W]);
         upd[j].set   = 1'b1;
      end
      upd[NUM_WB_PORTS].valid = init_done_q & rollback_valid;
      upd[NUM_WB_PORTS].addr  = phys_addr_t'(rollback_phys);
      upd[NUM_WB_PORTS].set   = 1'b1;
   end

   phys_reg_set_decoder #(
      .NUM_PHYS (NUM_PHYS),
      .NUM_UPD  (NUM_UPD)
   ) u_set_decoder (
      .upd      (upd),
      .set_mask (set_mask)
   );

   // Allocation clear mask; phys 0 is hardwired ready so it can never be cleared
   always_comb begin
      clr_mask = '0;
      if (init_done_q && alloc_valid && (alloc_phys != '0)) begin
         clr_mask[alloc_phys] = 1'b1;
      end
   end

   // Effective transitions drive the incremental count: alloc beats set to the same address
   always_comb begin
      eff_set    = set_mask & ~ready_q & ~clr_mask;
      eff_set[0] = 1'b0;
      eff_clr    = clr_mask & ready_q;
      dec_cnt    = '0;
      for (int p = 0; p < NUM_PHYS; p++) begin
         dec_cnt = dec_cnt + {{PHYS_W{1'b0}}, eff_set[p]};
      end
   end

   // Next-state: synchronous reset restores all-ready, otherwise apply set then clear
   always_comb begin
      ready_d     = ready_q;
      count_d     = count_q;
      init_done_d = 1'b1;
      if (!rst) begin
         ready_d     = '1;
         count_d     = '0;
         init_done_d = 1'b0;
      end else begin
         ready_d    = (ready_q | set_mask) & ~clr_mask;
         ready_d[0] = 1'b1;
         count_d    = count_q + {{PHYS_W{1'b0}}, |eff_clr} - dec_cnt;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      ready_q     <= ready_d;
      count_q     <= count_d;
      init_done_q <= init_done_d;
   end

   // Source lookup: table bit, or a writeback landing on the same address this cycle
   generate
      for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_rd
         logic [PHYS_W-1:0] rs_addr;
         logic              wb_hit;
         assign rs_addr = rs_phys[g*PHYS_W +: PHYS_W];
         // Zero-cycle bypass from any writeback port
         always_comb begin
            wb_hit = 1'b0;
            for (int j = 0; j < NUM_WB_PORTS; j++) begin
               if (wb_valid[j] && (wb_phys[j*PHYS_W +: PHYS_W] == rs_addr)) begin
                  wb_hit = 1'b1;
               end
            end
         end
         assign rs_ready[g] = (rs_addr == '0) | ready_q[rs_addr] | wb_hit;
      end
   endgenerate

   assign not_ready_count = count_q;
   assign init_done       = init_done_q;

   // Reference popcount of the table, used only to cross-check the incremental counter
   always_comb begin
      not_ready_pop = '0;
      for (int p = 0; p < NUM_PHYS; p++) begin
         not_ready_pop = not_ready_pop + {{PHYS_W{1'b0}}, ~ready_q[p]};
      end
   end

   // Protocol and consistency checks; they observe but never steer the datapath
   always_ff @(posedge clk) begin
      if (rst && init_done_q) begin
         if (alloc_valid) begin
            assert (alloc_phys != '0)
               else $warning("alloc of phys 0 ignored");
            assert ((alloc_phys == '0) || ready_q[alloc_phys])
               else $warning("alloc of already-clear phys %0d", alloc_phys);
         end
         assert (count_q == not_ready_pop)
            else $error("not_ready_count %0d disagrees with table popcount %0d", count_q, not_ready_pop);
         assert (!$isunknown(rs_ready))
            else $error("rs_ready carries X after init");
      end
   end

endmodule

// File: tb/tb_phys_reg_ready_table.sv
// Directed bench for phys_reg_ready_table with a bit-array reference model and expectation queue.
// Latency: checks combinational rs_ready and registered count/init_done each cycle.
// Backpressure: n/a.
module tb_phys_reg_ready_table;

   localparam int NP = 64;
   localparam int PW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          alloc_valid;
   logic [PW-1:0] alloc_phys;
   logic          rollback_valid;
   logic [PW-1:0] rollback_phys;
   logic [2:0]    wb_valid;
   logic [3*PW-1:0] wb_phys;
   logic [2*PW-1:0] rs_phys;
   logic [1:0]    rs_ready;
   logic [PW:0]   not_ready_count;
   logic          init_done;

   typedef struct {
      logic [1:0]  rs;
      logic [PW:0] cnt;
      logic        init;
   } exp_t;

   exp_t sb [$];

   logic [NP-1:0] m_ready;
   logic          m_init;
   int            tests = 0;
   int            fails = 0;

   phys_reg_ready_table #(
      .NUM_PHYS       (NP),
      .NUM_READ_PORTS (2),
      .NUM_WB_PORTS   (3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .alloc_valid     (alloc_valid),
      .alloc_phys      (alloc_phys),
      .rollback_valid  (rollback_valid),
      .rollback_phys   (rollback_phys),
      .wb_valid        (wb_valid),
      .wb_phys         (wb_phys),
      .rs_phys         (rs_phys),
      .rs_ready        (rs_ready),
      .not_ready_count (not_ready_count),
      .init_done       (init_done)
   );

   always #5 clk = ~clk;

   function automatic logic model_rs(input int r);
      logic hit;
      hit = (r == 0) || m_ready[r];
      for (int j = 0; j < 3; j++) begin
         if (wb_valid[j] && (int'(wb_phys[j*PW +: PW]) == r)) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic [PW:0] model_count();
      logic [PW:0] c;
      c = '0;
      for (int p = 0; p < NP; p++) begin
         if (!m_ready[p]) c = c + 1'b1;
      end
      return c;
   endfunction

   task automatic model_update();
      if (!rst) begin
         m_ready = '1;
         m_init  = 1'b0;
      end else begin
         if (m_init) begin
            for (int j = 0; j < 3; j++) begin
               if (wb_valid[j]) m_ready[wb_phys[j*PW +: PW]] = 1'b1;
            end
            if (rollback_valid) m_ready[rollback_phys] = 1'b1;
            if (alloc_valid && (alloc_phys != '0)) m_ready[alloc_phys] = 1'b0;
            m_ready[0] = 1'b1;
         end
         m_init = 1'b1;
      end
   endtask

   // Called just after a rising edge: drive one cycle of inputs, check mid-cycle, advance model
   task automatic step(input string tag, input logic rv, input logic av, input int ap,
                       input logic bv, input int bp, input logic [2:0] wv,
                       input int w0, input int w1, input int w2, input int r0, input int r1);
      exp_t e;
      rst            = rv;
      alloc_valid    = av;
      alloc_phys     = PW'(ap);
      rollback_valid = bv;
      rollback_phys  = PW'(bp);
      wb_valid       = wv;
      wb_phys        = {PW'(w2), PW'(w1), PW'(w0)};
      rs_phys        = {PW'(r1), PW'(r0)};
      e.rs   = {model_rs(r1), model_rs(r0)};
      e.cnt  = model_count();
      e.init = m_init;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      assert (rs_ready === e.rs)
         else begin fails++; $error("FAIL %s rs_ready got %b exp %b", tag, rs_ready, e.rs); end
      tests++;
      assert (not_ready_count === e.cnt)
         else begin fails++; $error("FAIL %s count got %0d exp %0d", tag, not_ready_count, e.cnt); end
      tests++;
      assert (init_done === e.init)
         else begin fails++; $error("FAIL %s init_done got %b exp %b", tag, init_done, e.init); end
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic rd(input string tag, input int r0, input int r1);
      step(tag, 1'b1, 1'b0, 0, 1'b0, 0, 3'b000, 0, 0, 0, r0, r1);
   endtask

   initial begin
      rst = 1'b0; alloc_valid = 1'b0; alloc_phys = '0; rollback_valid = 1'b0;
      rollback_phys = '0; wb_valid = '0; wb_phys = '0; rs_phys = '0;
      m_ready = '1; m_init = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // reset held, then released: init_done rises one cycle later
      step("reset_hold", 1'b0, 1'b0, 0, 1'b0, 0, 3'b000, 0, 0, 0, 1, 2);
      rd("release", 3, 4);
      for (int p = 0; p < NP / 2; p++) rd("sweep", 2 * p, 2 * p + 1);

      // alloc 40, then wb bypass on port 1, then table set
      step("alloc40", 1'b1, 1'b1, 40, 1'b0, 0, 3'b000, 0, 0, 0, 40, 0);
      rd("read40_clear", 40, 39);
      step("wb40_bypass", 1'b1, 1'b0, 0, 1'b0, 0, 3'b010, 0, 40, 0, 40, 0);
      rd("read40_set", 40, 0);

      // alloc beats same-cycle wb; duplicate wb to one address sets once
      step("alloc33_wb33", 1'b1, 1'b1, 33, 1'b0, 0, 3'b001, 33, 0, 0, 33, 0);
      rd("read33_clear", 33, 0);
      step("alloc45", 1'b1, 1'b1, 45, 1'b0, 0, 3'b000, 0, 0, 0, 45, 33);
      step("wb_dup45", 1'b1, 1'b0, 0, 1'b0, 0, 3'b101, 45, 0, 45, 45, 33);
      rd("after_dup45", 45, 33);
      step("wb33_clean", 1'b1, 1'b0, 0, 1'b0, 0, 3'b001, 33, 0, 0, 33, 45);
      rd("clean", 33, 45);

      // phys 0 is immune to alloc and always reads ready
      step("alloc0_wb0", 1'b1, 1'b1, 0, 1'b0, 0, 3'b001, 0, 0, 0, 0, 0);
      rd("read0", 0, 1);

      // rollback sets without bypass; alloc and rollback on different addresses both land
      step("alloc50", 1'b1, 1'b1, 50, 1'b0, 0, 3'b000, 0, 0, 0, 50, 0);
      step("rollback50", 1'b1, 1'b0, 0, 1'b1, 50, 3'b000, 0, 0, 0, 50, 0);
      rd("read50", 50, 0);
      step("alloc52", 1'b1, 1'b1, 52, 1'b0, 0, 3'b000, 0, 0, 0, 52, 51);
      step("alloc51_rb52", 1'b1, 1'b1, 51, 1'b1, 52, 3'b000, 0, 0, 0, 51, 52);
      rd("read51_52", 51, 52);
      step("wb51_clean", 1'b1, 1'b0, 0, 1'b0, 0, 3'b100, 0, 0, 51, 51, 52);

      // reset mid-stream discards pending allocs and restarts init
      step("alloc60", 1'b1, 1'b1, 60, 1'b0, 0, 3'b000, 0, 0, 0, 60, 61);
      step("alloc61", 1'b1, 1'b1, 61, 1'b0, 0, 3'b000, 0, 0, 0, 60, 61);
      step("alloc62_rst", 1'b0, 1'b1, 62, 1'b0, 0, 3'b000, 0, 0, 0, 60, 61);
      step("rst_hold", 1'b0, 1'b0, 0, 1'b0, 0, 3'b000, 0, 0, 0, 60, 62);
      rd("rerelease", 61, 62);
      rd("post_reset", 60, 62);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
